// File: rtl/traffic_light_fsm.sv
// Two-road traffic light sequencer: main road rests green, and a latched side-road
// request is served through yellow / all-red / side-green / side-yellow / all-red.
module traffic_light_fsm #(
  parameter int MIN_GREEN  = 8,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 1,
  parameter int SIDE_GREEN = 6,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic [2:0] main_lt,
  output logic [2:0] side_lt,
  output logic       req_pend,
  output logic       served
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] SG_LAST = CNT_W'(SIDE_GREEN - 1);

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               req_pend_q, req_pend_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + CNT_W'(1);
    case (state_q)
      MG: begin
        // Timer parks at its last value so main green can rest indefinitely.
        if (timer_q == MG_LAST) begin
          timer_d = timer_q;
          if (req_pend_q || req) begin
            state_d = MY;
            timer_d = '0;
          end
        end
      end
      MY:  if (timer_q == Y_LAST)  begin state_d = AR1; timer_d = '0; end
      AR1: if (timer_q == AR_LAST) begin state_d = SG;  timer_d = '0; end
      SG:  if (timer_q == SG_LAST) begin state_d = SY;  timer_d = '0; end
      SY:  if (timer_q == Y_LAST)  begin state_d = AR2; timer_d = '0; end
      AR2: if (timer_q == AR_LAST) begin state_d = MG;  timer_d = '0; end
      default: begin
        state_d = MG;
        timer_d = '0;
      end
    endcase
  end

  // A request that immediately launches MY is consumed directly and never latched.
  always_comb begin
    req_pend_d = req_pend_q;
    if (state_d == SG && state_q != SG) begin
      req_pend_d = 1'b0;
    end else if (req && (state_q inside {MG, MY, AR1}) &&
                 !(state_q == MG && state_d == MY)) begin
      req_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MG;
      timer_q    <= '0;
      req_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      req_pend_q <= req_pend_d;
    end
  end

  always_comb begin
    main_lt = LAMP_G;
    side_lt = LAMP_R;
    case (state_q)
      MG:      begin main_lt = LAMP_G; side_lt = LAMP_R; end
      MY:      begin main_lt = LAMP_Y; side_lt = LAMP_R; end
      AR1:     begin main_lt = LAMP_R; side_lt = LAMP_R; end
      SG:      begin main_lt = LAMP_R; side_lt = LAMP_G; end
      SY:      begin main_lt = LAMP_R; side_lt = LAMP_Y; end
      AR2:     begin main_lt = LAMP_R; side_lt = LAMP_R; end
      default: begin main_lt = LAMP_G; side_lt = LAMP_R; end
    endcase
  end

  assign req_pend = req_pend_q;
  assign served   = (state_q == AR2) && (timer_q == AR_LAST);

endmodule
